// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler
// Round-robin scheduler that time-shares one external 4-bit feedback
// accumulator (result <= rst ? 0 : result + a) among NREQ requesters.
// For each granted transaction it clears the accumulator for one cycle.
// It then feeds the owner's operand for cnt cycles. Finally it reports the
// 8-bit sum with a one-cycle done pulse.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   req          per-requester request, held until that requester's done
//   req_op       per-requester 4-bit operand, slice i = [4i+3:4i]
//   req_cnt      per-requester repeat count, slice i = [CNT_W*i +: CNT_W]
//   gnt          one-hot grant, CLEAR through DONE of the owner
//   busy         high whenever the controller is not idle
//   done         one-cycle completion pulse
//   done_id      index of the finishing requester (valid with done)
//   done_result  accumulated result (valid with done, 0 otherwise)
//   add_a        adder operand input
//   add_rst      adder synchronous clear
//   add_result   adder accumulator output
module adder_rr_scheduler #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [4*NREQ-1:0]     req_op,
  input  logic [CNT_W*NREQ-1:0] req_cnt,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            done_id,
  output logic [7:0]            done_result,
  output logic [3:0]            add_a,
  output logic                  add_rst,
  input  logic [7:0]            add_result
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_ACCUM,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [2:0]       ptr, ptr_nxt;   // last served requester
  logic [2:0]       id, id_nxt;     // current owner
  logic [3:0]       op, op_nxt;     // latched operand
  logic [CNT_W-1:0] rem, rem_nxt;   // remaining accumulate cycles

  // Round-robin pick: first requester set, searching ptr+1, ptr+2, ... mod NREQ.
  logic             pick_valid;
  logic [2:0]       pick_id;
  logic [IDX_W-1:0] cand;
  logic [3:0]       pick_op;
  logic [CNT_W-1:0] pick_cnt;

  // NOTE: every signal assigned in always_comb receives a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    cand       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NREQ);
      if (!pick_valid && req[cand]) begin
        pick_valid = 1'b1;
        pick_id    = 3'(cand);
      end
    end
  end

  // Constant-index mux of the picked requester's operand and count.
  always_comb begin
    pick_op  = '0;
    pick_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_id == 3'(i)) begin
        pick_op  = req_op[4*i +: 4];
        pick_cnt = req_cnt[CNT_W*i +: CNT_W];
      end
    end
  end

  // Next-state and Moore output decode.
  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    id_nxt      = id;
    op_nxt      = op;
    rem_nxt     = rem;
    gnt         = '0;
    busy        = (state != S_IDLE);
    done        = 1'b0;
    done_id     = '0;
    done_result = '0;
    add_a       = '0;

    unique case (state)
      S_IDLE: begin
        if (pick_valid) begin
          id_nxt    = pick_id;
          op_nxt    = pick_op;
          rem_nxt   = pick_cnt;
          state_nxt = S_CLEAR;
        end
      end
      S_CLEAR: begin
        gnt       = NREQ'(1) << id;
        state_nxt = (rem == '0) ? S_DONE : S_ACCUM;
      end
      S_ACCUM: begin
        gnt     = NREQ'(1) << id;
        add_a   = op;
        rem_nxt = rem - CNT_W'(1);
        if (rem == CNT_W'(1)) state_nxt = S_DONE;
      end
      S_DONE: begin
        gnt         = NREQ'(1) << id;
        done        = 1'b1;
        done_id     = id;
        done_result = add_result;
        ptr_nxt     = id;
        state_nxt   = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // The adder clears together with the controller, and again in CLEAR.
  assign add_rst = rst | (state == S_CLEAR);

  // NOTE: state registers use non-blocking assignments so all flops update
  // from the same pre-edge values. The latched id/op/count are reset too,
  // which keeps the outputs free of X after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      ptr   <= 3'(NREQ - 1);
      id    <= '0;
      op    <= '0;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      id    <= id_nxt;
      op    <= op_nxt;
      rem   <= rem_nxt;
    end
  end

endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Testbench for adder_rr_scheduler: behavioural accumulator model,
// table-driven single transactions, and hand-written multi-cycle sequences.
module tb_adder_rr_scheduler;

  logic        clk;
  logic        rst;

  // Main instance: NREQ=4, CNT_W=4
  logic [3:0]  req;
  logic [15:0] req_op;
  logic [15:0] req_cnt;
  logic [3:0]  gnt;
  logic        busy, done, add_rst;
  logic [2:0]  done_id;
  logic [7:0]  done_result, add_result;
  logic [3:0]  add_a;

  // Wide-count instance: NREQ=4, CNT_W=5
  logic [3:0]  w_req;
  logic [15:0] w_op;
  logic [19:0] w_cnt;
  logic [3:0]  w_gnt;
  logic        w_busy, w_done, w_add_rst;
  logic [2:0]  w_done_id;
  logic [7:0]  w_done_result, w_add_result;
  logic [3:0]  w_add_a;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  adder_rr_scheduler #(.NREQ(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_cnt(req_cnt),
    .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
    .done_result(done_result), .add_a(add_a), .add_rst(add_rst),
    .add_result(add_result)
  );

  adder_rr_scheduler #(.NREQ(4), .CNT_W(5)) dut_wide (
    .clk(clk), .rst(rst), .req(w_req), .req_op(w_op), .req_cnt(w_cnt),
    .gnt(w_gnt), .busy(w_busy), .done(w_done), .done_id(w_done_id),
    .done_result(w_done_result), .add_a(w_add_a), .add_rst(w_add_rst),
    .add_result(w_add_result)
  );

  // Behavioural four_bit_adder_with_feedback models.
  always @(posedge clk) begin
    add_result   <= add_rst   ? 8'd0 : add_result   + {4'd0, add_a};
    w_add_result <= w_add_rst ? 8'd0 : w_add_result + {4'd0, w_add_a};
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    req = '0; req_op = '0; req_cnt = '0;
    w_req = '0; w_op = '0; w_cnt = '0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // One isolated transaction from IDLE; checks every cycle through done.
  task automatic run_txn(input int id, input int op, input int cnt, input int exp);
    req     = 4'(1) << id;
    req_op  = 16'(op) << (4 * id);
    req_cnt = 16'(cnt) << (4 * id);
    tick();  // cycle 1: CLEAR
    for (int c = 1; c <= cnt + 2; c++) begin
      check($sformatf("txn%0d_gnt_c%0d", id, c), gnt, 4'(1) << id);
      check($sformatf("txn%0d_busy_c%0d", id, c), busy, 1);
      if (c == cnt + 2) begin
        check($sformatf("txn%0d_done", id), done, 1);
        check($sformatf("txn%0d_done_id", id), done_id, id);
        check($sformatf("txn%0d_result", id), done_result, exp);
        check($sformatf("txn%0d_add_a_done", id), add_a, 0);
      end else begin
        check($sformatf("txn%0d_nodone_c%0d", id, c), done, 0);
        check($sformatf("txn%0d_res0_c%0d", id, c), done_result, 0);
        check($sformatf("txn%0d_add_a_c%0d", id, c), add_a, (c >= 2) ? op : 0);
        check($sformatf("txn%0d_add_rst_c%0d", id, c), add_rst, (c == 1) ? 1 : 0);
        tick();
      end
    end
    req = '0;
    tick();
    check($sformatf("txn%0d_idle_busy", id), busy, 0);
    check($sformatf("txn%0d_idle_gnt", id), gnt, 0);
    check($sformatf("txn%0d_idle_done", id), done, 0);
  endtask

  typedef struct {
    int id;
    int op;
    int cnt;
    int exp;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int n;
    int ndone;
    int last;
    int exp_ids[6];
    int exp_res[6];

    vecs[0] = '{id: 2, op: 3,  cnt: 5,  exp: 15};
    vecs[1] = '{id: 1, op: 9,  cnt: 0,  exp: 0};
    vecs[2] = '{id: 0, op: 15, cnt: 15, exp: 225};
    vecs[3] = '{id: 3, op: 1,  cnt: 1,  exp: 1};
    vecs[4] = '{id: 1, op: 7,  cnt: 4,  exp: 28};
    exp_ids = '{0, 1, 2, 3, 0, 1};
    exp_res = '{2, 4, 6, 8, 2, 4};

    // Reset state
    req = '0; req_op = '0; req_cnt = '0;
    w_req = '0; w_op = '0; w_cnt = '0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_result", done_result, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_rst", add_rst, 1);
    check("rst_add_result", add_result, 0);
    rst = 1'b0;
    tick();
    check("post_rst_add_rst", add_rst, 0);

    // Table-driven single transactions
    for (int v = 0; v < 5; v++) run_txn(vecs[v].id, vecs[v].op, vecs[v].cnt, vecs[v].exp);

    // Fairness: all four requesting continuously, ptr starts at 3 after reset
    do_reset();
    req     = 4'hF;
    req_op  = {4'd4, 4'd3, 4'd2, 4'd1};
    req_cnt = {4'd2, 4'd2, 4'd2, 4'd2};
    ndone = 0;
    last  = 0;
    n     = 0;
    while (ndone < 6 && n < 80) begin
      tick();
      n++;
      check($sformatf("fair_onehot_c%0d", n), $countones(gnt) <= 1, 1);
      if (done) begin
        check($sformatf("fair_id_%0d", ndone), done_id, exp_ids[ndone]);
        check($sformatf("fair_res_%0d", ndone), done_result, exp_res[ndone]);
        if (ndone > 0) check($sformatf("fair_gap_%0d", ndone), n - last, 5);
        last = n;
        ndone++;
      end
    end
    check("fair_count", ndone, 6);

    // Reset in the middle of ACCUM
    do_reset();
    req     = 4'b1000;
    req_op  = 16'hF000;
    req_cnt = 16'hA000;
    tick();  // cycle 1 CLEAR
    tick();  // cycle 2
    tick();  // cycle 3
    tick();  // cycle 4 ACCUM
    check("mid_gnt_before", gnt, 4'b1000);
    check("mid_add_a_before", add_a, 15);
    rst     = 1'b1;
    req     = 4'b1001;
    req_op  = 16'hF005;
    req_cnt = 16'hA001;
    tick();
    check("mid_rst_gnt", gnt, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_add_result", add_result, 0);
    rst = 1'b0;
    tick();
    check("mid_rst_next_gnt", gnt, 4'b0001);

    // Operand/count change mid-transaction: latched values are used
    do_reset();
    req     = 4'b0010;
    req_op  = 16'h0050;
    req_cnt = 16'h0040;
    tick();  // cycle 1
    tick();  // cycle 2
    tick();  // cycle 3
    n = 3;
    req_op  = 16'h00C0;
    req_cnt = 16'h0090;
    while (!done && n < 20) begin
      tick();
      n++;
    end
    check("opchg_done", done, 1);
    check("opchg_cycle", n, 6);
    check("opchg_result", done_result, 20);
    req = '0;
    tick();
    check("opchg_idle", busy, 0);

    // Wide count: 15 * 31 = 465 -> 209 mod 256
    w_req = 4'b0001;
    w_op  = 16'h000F;
    w_cnt = 20'd31;
    n = 0;
    while (!w_done && n < 40) begin
      tick();
      n++;
    end
    check("wide_done", w_done, 1);
    check("wide_cycle", n, 33);
    check("wide_id", w_done_id, 0);
    check("wide_result", w_done_result, 209);
    w_req = '0;
    tick();
    check("wide_idle", w_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
- Round-robin scheduler that shares one four_bit_adder_with_feedback accumulator among NREQ requesters.
- Per granted transaction it clears the accumulator, feeds the requester's 4-bit operand for a requested number of cycles, then returns the 8-bit accumulated result with a one-cycle done pulse.
- Sits between requester logic and the adder instance; owns the adder's a and rst inputs exclusively.

Parameters:
NREQ, 4, number of requesters (2..8)
CNT_W, 4, width of per-request repeat count

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
req  in  NREQ  request per requester; held until own done
req_op  in  4*NREQ  operand per requester, slice i = [4i+3:4i]; stable while req high
req_cnt  in  CNT_W*NREQ  add-repeat count per requester, slice i; stable while req high
gnt  out  NREQ  one-hot grant, high from CLEAR through DONE of owner's transaction
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse, result valid
done_id  out  3  index of finishing requester, valid with done
done_result  out  8  accumulated result, valid with done, 0 otherwise
add_a  out  4  adder operand input
add_rst  out  1  adder synchronous clear
add_result  in  8  adder accumulator output

Behaviour:
- Adder contract: at each clk edge, result <= add_rst ? 0 : result + add_a, modulo 256.
- Reset (sync, rst high at edge): state=IDLE, gnt=0, done=0, done_id=0, busy=0, add_a=0, rr pointer=NREQ-1 (requester 0 highest priority). add_rst = rst OR (state==CLEAR), so the adder clears with the controller.
- Outputs are Moore-decoded from registered state plus latched id/op/count.
- States:
  - IDLE: add_a=0, gnt=0. If any req, pick the first set bit searching ptr+1, ptr+2, ... (mod NREQ). Latch id, op, cnt. Go to CLEAR.
  - CLEAR (1 cycle): add_rst=1, add_a=0, gnt[id]=1. Next state is DONE if cnt==0, else ACCUM with remaining=cnt.
  - ACCUM (cnt cycles): add_a=op, gnt[id]=1. Decrement remaining each edge. Go to DONE when remaining==1 at the edge.
  - DONE (1 cycle): add_a=0, done=1, done_id=id, done_result=add_result, gnt[id]=1. Then ptr<=id, go to IDLE.
- Latency: if req is sampled at edge E0, CLEAR occupies cycle 1, ACCUM cycles 2..cnt+1, and done is high in cycle cnt+2. Transaction length is cnt+3 cycles including the IDLE bubble.
- cnt==0: path is CLEAR then DONE; done_result=0.
- Wrap-around: result = (op*cnt) mod 256. No overflow flag. With CNT_W=4 the maximum is 225, so no wrap.
- req changes while not granted: ignored until the next IDLE sample. The latched op/cnt are used even if inputs change mid-transaction.
- Owner still holding req during its DONE: treated as a new request in the next IDLE. Round-robin from ptr=id then serves other pending requesters first.
- Dropping req mid-transaction: transaction completes normally.
- rst mid-transaction: abort at that edge. No done pulse. Adder cleared. ptr reset.
- One-hot invariant: gnt has at most one bit set. add_a is nonzero only in ACCUM.

Test Plan:
- Single: req[2]=1, op=3, cnt=5 sampled at E0 -> gnt=4'b0100 cycles 1..7; add_a=3 cycles 2..6; done in cycle 7 with done_id=2, done_result=15; busy low in cycle 8.
- Zero count: req[1], op=9, cnt=0 -> CLEAR then DONE; done in cycle 2 with result 0; add_a stays 0 throughout.
- Fairness: all four req high, op=i+1, cnt=2, held continuously -> grant order 0,1,2,3,0,1. Results are 2,4,6,8,2,4, one done every 5 cycles.
- Reset mid-op: req[3], op=15, cnt=10; assert rst in ACCUM cycle 4 -> next cycle gnt=0, busy=0, no done, add_result=0. After release, req[3] and req[0] pending -> requester 0 granted first.
- Wrap (CNT_W=5): req[0], op=15, cnt=31 -> done_result=209 (465 mod 256), done in cycle 33.
- Operand change: modify req_op of the granted requester during ACCUM -> result still uses the latched operand.
